btn_evt_ctrl: RTL and testbench

BTN_EVT_CTRL -- requirements
Module: btn_evt_ctrl

---
 rtl/btn_evt_pkg.sv | 26 ++
 rtl/btn_evt_if.sv | 21 ++
 rtl/btn_evt_ctrl_tick.sv | 29 ++
 rtl/btn_evt_ctrl.sv | 162 ++++++++++++++++
 tb/tb_btn_evt_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller: FSM states, event codes
// and a small sizing helper.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS    = 3'd1,
        ST_HELD     = 3'd2,
        ST_WAIT_DBL = 3'd3,
        ST_SECOND   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        EVT_SHORT  = 2'b00,
        EVT_DOUBLE = 2'b01,
        EVT_LONG   = 2'b10,
        EVT_REPEAT = 2'b11
    } evt_code_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_evt_if.sv
// Event handshake bundle between the controller (master) and its consumer.
// Signals: evt_valid/evt_code from master, evt_ready from slave.
interface btn_evt_if;

    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );

endinterface

// File: rtl/btn_evt_ctrl_tick.sv
// evt_tick: free-running prescaler producing a one-clock tick every TICK_DIV
// clocks. Ports: clk, rst (async active-low), tick (pulse out).
module evt_tick #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(TICK_DIV - 1));
    assign tick = wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_evt_ctrl.sv
// btn_evt_ctrl: classifies a debounced button into SHORT/DOUBLE/LONG
// (and REPEAT when BTN_EVT_REPEAT_EN is defined) events with a valid/ready
// output register and a sticky overflow flag.
// Ports: clk, rst (async active-low), db (switch level), evt_valid,
// evt_code, evt_ready (consumer handshake), ovf (event dropped).
module btn_evt_ctrl
    import btn_evt_pkg::*;
#(
    parameter int TICK_DIV   = 10,
    parameter int LONG_TICKS = 20,
    parameter int DBL_TICKS  = 8,
    parameter int REP_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       db,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       ovf
);

    localparam logic [2:0] IDLE     = ST_IDLE;
    localparam logic [2:0] PRESS    = ST_PRESS;
    localparam logic [2:0] HELD     = ST_HELD;
    localparam logic [2:0] WAIT_DBL = ST_WAIT_DBL;
    localparam logic [2:0] SECOND   = ST_SECOND;

    localparam int TMAX = max3(LONG_TICKS, DBL_TICKS, REP_TICKS);
    localparam int TW   = $clog2(TMAX + 1);

    logic          db_q;
    logic          armed;
    logic          rise;
    logic          fall;
    logic          tick;
    logic [TW-1:0] timer;
    logic [2:0]    state;
    logic [2:0]    nxt;
    logic          emit;
    logic [1:0]    emit_code;
    logic          rep_clr;
    logic          tmr_clr;

    evt_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // A press already in progress when reset releases must not count:
    // rises are ignored until db has been seen low once.
    assign rise = db & ~db_q & armed;
    assign fall = ~db & db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            db_q <= db;
            if (!db) begin
                armed <= 1'b1;
            end
        end
    end

    // Edges are tested before timer expiry so they win on a tie.
    always_comb begin
        nxt       = state;
        emit      = 1'b0;
        emit_code = EVT_SHORT;
        rep_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    nxt = PRESS;
                end
            end
            PRESS: begin
                if (fall) begin
                    nxt = WAIT_DBL;
                end else if (db && timer >= TW'(LONG_TICKS)) begin
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                    nxt       = HELD;
                end
            end
            HELD: begin
                if (fall) begin
                    nxt = IDLE;
                end
`ifdef BTN_EVT_REPEAT_EN
                else if (db && timer >= TW'(REP_TICKS)) begin
                    emit      = 1'b1;
                    emit_code = EVT_REPEAT;
                    rep_clr   = 1'b1;
                end
`endif
            end
            WAIT_DBL: begin
                if (rise) begin
                    nxt = SECOND;
                end else if (timer >= TW'(DBL_TICKS)) begin
                    emit      = 1'b1;
                    emit_code = EVT_SHORT;
                    nxt       = IDLE;
                end
            end
            SECOND: begin
                if (fall) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                    nxt       = IDLE;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    assign tmr_clr = (nxt != state) | rep_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (tmr_clr) begin
            timer <= '0;
        end else if (tick && timer != '1) begin
            timer <= timer + 1'b1;
        end
    end

    // Output slot: loads when empty or being accepted, otherwise the new
    // event is dropped and flagged. The FSM never waits on evt_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
            ovf       <= 1'b0;
        end else if (!evt_valid || evt_ready) begin
            evt_valid <= emit;
            if (emit) begin
                evt_code <= emit_code;
            end
        end else if (emit) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_btn_evt_ctrl.sv
// Directed bench for btn_evt_ctrl: short, long, double, overflow and
// mid-press reset scenarios with hand-computed expectations.
module tb_btn_evt_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic db  = 1'b0;
    logic ovf;

    btn_evt_if bus ();

    btn_evt_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .db       (db),
        .evt_valid(bus.evt_valid),
        .evt_code (bus.evt_code),
        .evt_ready(bus.evt_ready),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         n_cmp = 0;
    int         n_err = 0;
    int         hi_n  = 0;
    logic [1:0] ev_code[$];
    int         ev_cyc[$];

    always @(negedge clk) begin
        if (bus.evt_valid) hi_n++;
        if (bus.evt_valid && bus.evt_ready) begin
            ev_code.push_back(bus.evt_code);
            ev_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic int code_at(input int i);
        return (ev_code.size() > i) ? int'(ev_code[i]) : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (ev_cyc.size() > i) ? ev_cyc[i] : -100000;
    endfunction

    function automatic int in_rng(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 1 : 0;
    endfunction

    int n0, h0, c0, lat;

    initial begin
        bus.evt_ready = 1'b1;
        step(3);
        @(negedge clk);
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_code", bus.evt_code, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(5);

        // single short press
        n0 = ev_code.size();
        h0 = hi_n;
        db = 1'b1;
        step(50);
        db = 1'b0;
        c0 = cyc;
        step(150);
        chk("short_cnt", ev_code.size() - n0, 1);
        chk("short_code", code_at(n0), 0);
        lat = cyc_at(n0) - c0;
        chk($sformatf("short_lat=%0d in[70:85]", lat), in_rng(lat, 70, 85), 1);
        chk("short_width", hi_n - h0, 1);

        // long hold
        n0 = ev_code.size();
        db = 1'b1;
        c0 = cyc;
        step(300);
        db = 1'b0;
        step(150);
        chk("long_code", code_at(n0), 2);
        lat = cyc_at(n0) - c0;
        chk($sformatf("long_lat=%0d in[190:205]", lat), in_rng(lat, 190, 205), 1);
`ifdef BTN_EVT_REPEAT_EN
        chk("rep_code", code_at(n0 + 1), 3);
        chk("rep_gap", cyc_at(n0 + 1) - cyc_at(n0), 50);
`else
        chk("long_cnt", ev_code.size() - n0, 1);
`endif

        // double click
        n0 = ev_code.size();
        db = 1'b1;
        step(30);
        db = 1'b0;
        step(20);
        db = 1'b1;
        step(30);
        db = 1'b0;
        c0 = cyc;
        step(150);
        chk("dbl_cnt", ev_code.size() - n0, 1);
        chk("dbl_code", code_at(n0), 1);
        chk("dbl_lat", cyc_at(n0) - c0, 1);

        // overflow with consumer stalled
        bus.evt_ready = 1'b0;
        n0 = ev_code.size();
        db = 1'b1;
        step(50);
        db = 1'b0;
        step(150);
        @(negedge clk);
        chk("ovf_first_valid", bus.evt_valid, 1);
        chk("ovf_pre", ovf, 0);
        @(posedge clk);
        #2 db = 1'b1;
        step(50);
        db = 1'b0;
        step(150);
        @(negedge clk);
        chk("ovf_hold_valid", bus.evt_valid, 1);
        chk("ovf_hold_code", bus.evt_code, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_no_accept", ev_code.size() - n0, 0);
        @(posedge clk);
        #2 bus.evt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovf_drain_valid", bus.evt_valid, 0);
        chk("ovf_drain_cnt", ev_code.size() - n0, 1);
        chk("ovf_sticky", ovf, 1);

        // reset in the middle of a press
        step(2);
        n0 = ev_code.size();
        db = 1'b1;
        step(10);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", bus.evt_valid, 0);
        chk("mid_rst_code", bus.evt_code, 0);
        chk("mid_rst_ovf", ovf, 0);
        step(2);
        rst = 1'b1;
        step(38);
        db = 1'b0;
        step(150);
        chk("mid_rst_no_evt", ev_code.size() - n0, 0);
        chk("mid_rst_ovf_after", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
